// File: rtl/npu_host_pkg.sv
// Shared types and constants for the NPU host adapter: packet type codes,
// FSM state encoding and datapath widths.
package npu_host_pkg;

  localparam int CFG_W  = 26;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    TYPE_CFG  = 2'b00,
    TYPE_INP  = 2'b01,
    TYPE_RSV2 = 2'b10,
    TYPE_RSV3 = 2'b11
  } pkt_type_e;

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_CFG  = 2'd1,
    ST_INP  = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  function automatic logic is_reserved(input logic [1:0] ptype);
    return (ptype != TYPE_CFG) && (ptype != TYPE_INP);
  endfunction

endpackage

// File: rtl/npu_host_out_buf.sv
// Small synchronous FIFO used as the output prefetch buffer; exposes the
// head word combinationally and its occupancy.
module npu_host_out_buf #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: storage is not reset; count alone says which entries are valid, so
  // a reset here would only add reset fan-out to plain data flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata     = mem[rd_ptr];
  assign occupancy = count;

endmodule

// File: rtl/npu_host_adapter.sv
// Host-side bridge to the NPU: splits the host word stream into config/input
// FIFO pushes and drains the NPU output FIFO through a prefetch buffer.
module npu_host_adapter
  import npu_host_pkg::*;
#(
  parameter int LEN_W      = 16,
  parameter int OBUF_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] host_in_data,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  output logic [DATA_W-1:0] host_out_data,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [CFG_W-1:0]  npu_config_data,
  output logic              npu_config_fifo_write_enable,
  input  logic              npu_config_fifo_full,
  output logic [DATA_W-1:0] npu_input_data,
  output logic              npu_input_fifo_write_enable,
  input  logic              npu_input_fifo_full,
  input  logic [DATA_W-1:0] npu_output_data,
  output logic              npu_output_fifo_read_enable,
  input  logic              npu_output_fifo_empty,
  output logic              pkt_done,
  output logic              bad_header,
  output logic              busy
);

  localparam int OCC_W = $clog2(OBUF_DEPTH) + 1;
  localparam int SUM_W = OCC_W + 1;

  state_e           state;
  state_e           state_nxt;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_nxt;
  logic             active;
  logic             bad_set;
  logic [1:0]       hdr_type;
  logic [LEN_W-1:0] hdr_len;

  logic             inflight;
  logic [OCC_W-1:0] occ;
  logic [DATA_W-1:0] buf_head;
  logic             buf_pop;

  assign hdr_type = host_in_data[31:30];
  assign hdr_len  = host_in_data[LEN_W-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of evaluation order.
  // active holds every handshake output low while RST is asserted without
  // routing the reset net into combinational logic.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_HDR;
      cnt        <= '0;
      active     <= 1'b0;
      bad_header <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      active   <= 1'b1;
      inflight <= npu_output_fifo_read_enable;
      if (bad_set) bad_header <= 1'b1;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt                    = state;
    cnt_nxt                      = cnt;
    host_in_ready                = 1'b0;
    npu_config_fifo_write_enable = 1'b0;
    npu_input_fifo_write_enable  = 1'b0;
    pkt_done                     = 1'b0;
    bad_set                      = 1'b0;

    if (active) begin
      unique case (state)
        ST_HDR: begin
          host_in_ready = 1'b1;
          if (host_in_valid) begin
            bad_set = is_reserved(hdr_type);
            if (hdr_len == '0) begin
              pkt_done = 1'b1;
            end else begin
              cnt_nxt = hdr_len;
              unique case (hdr_type)
                TYPE_CFG: state_nxt = ST_CFG;
                TYPE_INP: state_nxt = ST_INP;
                default:  state_nxt = ST_DROP;
              endcase
            end
          end
        end
        ST_CFG: begin
          host_in_ready                = !npu_config_fifo_full;
          npu_config_fifo_write_enable = host_in_valid && !npu_config_fifo_full;
        end
        ST_INP: begin
          host_in_ready               = !npu_input_fifo_full;
          npu_input_fifo_write_enable = host_in_valid && !npu_input_fifo_full;
        end
        ST_DROP: begin
          host_in_ready = 1'b1;
        end
      endcase

      // Payload bookkeeping shared by CFG, INP and DROP.
      if ((state != ST_HDR) && host_in_valid && host_in_ready) begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == LEN_W'(1)) begin
          pkt_done  = 1'b1;
          state_nxt = ST_HDR;
        end
      end
    end
  end

  assign busy            = (state != ST_HDR);
  assign npu_config_data = (state == ST_CFG) ? host_in_data[CFG_W-1:0] : '0;
  assign npu_input_data  = (state == ST_INP) ? host_in_data : '0;

  // Reads in flight still need a slot, so they count against free space.
  assign npu_output_fifo_read_enable = active && !npu_output_fifo_empty &&
                                       ((SUM_W'(occ) + SUM_W'(inflight)) < SUM_W'(OBUF_DEPTH));

  assign host_out_valid = (occ != '0);
  assign host_out_data  = host_out_valid ? buf_head : '0;
  assign buf_pop        = host_out_valid && host_out_ready;

  npu_host_out_buf #(
    .DEPTH (OBUF_DEPTH),
    .WIDTH (DATA_W)
  ) u_out_buf (
    .clk       (CLK),
    .rst_n     (RST),
    .push      (inflight),
    .wdata     (npu_output_data),
    .pop       (buf_pop),
    .rdata     (buf_head),
    .occupancy (occ)
  );

endmodule

// File: tb/tb_npu_host_adapter.sv
// Scoreboard bench for npu_host_adapter: expected FIFO writes and host output
// words are queued at stimulus time and checked when the DUT produces them.
module tb_npu_host_adapter;

  localparam int LEN_W      = 16;
  localparam int OBUF_DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [31:0] host_in_data = '0;
  logic        host_in_valid = 1'b0;
  logic        host_in_ready;
  logic [31:0] host_out_data;
  logic        host_out_valid;
  logic        host_out_ready = 1'b0;
  logic [25:0] npu_config_data;
  logic        npu_config_fifo_write_enable;
  logic        npu_config_fifo_full = 1'b0;
  logic [31:0] npu_input_data;
  logic        npu_input_fifo_write_enable;
  logic        npu_input_fifo_full = 1'b0;
  logic [31:0] npu_output_data = '0;
  logic        npu_output_fifo_read_enable;
  logic        npu_output_fifo_empty = 1'b1;
  logic        pkt_done;
  logic        bad_header;
  logic        busy;

  always #5 CLK = ~CLK;

  npu_host_adapter #(.LEN_W(LEN_W), .OBUF_DEPTH(OBUF_DEPTH)) dut (
    .CLK                          (CLK),
    .RST                          (RST),
    .host_in_data                 (host_in_data),
    .host_in_valid                (host_in_valid),
    .host_in_ready                (host_in_ready),
    .host_out_data                (host_out_data),
    .host_out_valid               (host_out_valid),
    .host_out_ready               (host_out_ready),
    .npu_config_data              (npu_config_data),
    .npu_config_fifo_write_enable (npu_config_fifo_write_enable),
    .npu_config_fifo_full         (npu_config_fifo_full),
    .npu_input_data               (npu_input_data),
    .npu_input_fifo_write_enable  (npu_input_fifo_write_enable),
    .npu_input_fifo_full          (npu_input_fifo_full),
    .npu_output_data              (npu_output_data),
    .npu_output_fifo_read_enable  (npu_output_fifo_read_enable),
    .npu_output_fifo_empty        (npu_output_fifo_empty),
    .pkt_done                     (pkt_done),
    .bad_header                   (bad_header),
    .busy                         (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [25:0] cfg_q [$];
  logic [31:0] inp_q [$];
  logic [31:0] out_q [$];
  logic [31:0] npu_q [$];

  int          pd_cnt      = 0;
  int          rd_issued   = 0;
  int          rd_consumed = 0;
  logic        prev_stall  = 1'b0;
  logic [31:0] prev_data   = '0;
  logic [25:0] exp26;
  logic [31:0] exp32;

  // NPU output FIFO model: read data appears the cycle after the read enable.
  always @(posedge CLK) begin
    if (npu_output_fifo_read_enable) begin
      if (npu_q.size() > 0) npu_output_data <= npu_q.pop_front();
      else                  npu_output_data <= 32'hDEAD_BEEF;
    end
  end

  always begin
    @(posedge CLK);
    #1;
    npu_output_fifo_empty = (npu_q.size() == 0);
  end

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (npu_config_fifo_write_enable) begin
      n_checks++;
      if (npu_config_fifo_full) begin
        n_fail++;
        $display("FAIL cfg_we_while_full: write enable asserted with full=1");
      end else if (cfg_q.size() == 0) begin
        n_fail++;
        $display("FAIL cfg_unexpected: got write of %h, expected no write", npu_config_data);
      end else begin
        exp26 = cfg_q.pop_front();
        if (npu_config_data !== exp26) begin
          n_fail++;
          $display("FAIL cfg_data: got %h expected %h", npu_config_data, exp26);
        end
      end
    end
    if (npu_input_fifo_write_enable) begin
      n_checks++;
      if (npu_input_fifo_full) begin
        n_fail++;
        $display("FAIL inp_we_while_full: write enable asserted with full=1");
      end else if (inp_q.size() == 0) begin
        n_fail++;
        $display("FAIL inp_unexpected: got write of %h, expected no write", npu_input_data);
      end else begin
        exp32 = inp_q.pop_front();
        if (npu_input_data !== exp32) begin
          n_fail++;
          $display("FAIL inp_data: got %h expected %h", npu_input_data, exp32);
        end
      end
    end
    if (npu_output_fifo_read_enable) begin
      n_checks++;
      if (npu_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_underflow: read enable with NPU output FIFO empty");
      end else if (rd_issued - rd_consumed >= OBUF_DEPTH) begin
        n_fail++;
        $display("FAIL rd_overflow: read with %0d words held or in flight, limit %0d",
                 rd_issued - rd_consumed, OBUF_DEPTH);
      end
      rd_issued++;
    end
    if (host_out_valid && prev_stall) begin
      n_checks++;
      if (host_out_data !== prev_data) begin
        n_fail++;
        $display("FAIL out_hold: data changed to %h while stalled, expected %h", host_out_data, prev_data);
      end
    end
    if (host_out_valid && host_out_ready) begin
      n_checks++;
      rd_consumed++;
      if (out_q.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got %h, expected no word", host_out_data);
      end else begin
        exp32 = out_q.pop_front();
        if (host_out_data !== exp32) begin
          n_fail++;
          $display("FAIL out_data: got %h expected %h", host_out_data, exp32);
        end
      end
    end
    prev_stall = host_out_valid && !host_out_ready;
    prev_data  = host_out_data;
    if (pkt_done) pd_cnt++;
  end

  // Called at posedge+1; returns at posedge+1 after the word is accepted.
  task automatic send_word(input logic [31:0] d, input logic exp_done, output int waited);
    waited = 0;
    host_in_data  = d;
    host_in_valid = 1'b1;
    @(negedge CLK);
    while (!host_in_ready && waited < 50) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++;
    if (!host_in_ready) begin
      n_fail++;
      $display("FAIL accept_timeout: word %h not accepted within 50 cycles", d);
    end else if (pkt_done !== exp_done) begin
      n_fail++;
      $display("FAIL pkt_done_on_accept: word %h got %b expected %b", d, pkt_done, exp_done);
    end
    @(posedge CLK);
    #1;
    host_in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [7:0]  ctl;
    logic [89:0] buses;
    RST           = 1'b0;
    host_in_data  = 32'hFFFF_FFFF;
    host_in_valid = 1'b1;
    host_out_ready = 1'b1;
    idle(2);
    @(negedge CLK);
    ctl = {host_in_ready, host_out_valid, pkt_done, bad_header, busy,
           npu_config_fifo_write_enable, npu_input_fifo_write_enable, npu_output_fifo_read_enable};
    buses = {npu_config_data, npu_input_data, host_out_data};
    n_checks++;
    if (ctl !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 00000000", ctl);
    end
    n_checks++;
    if (buses !== '0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h expected 0", buses);
    end
    @(posedge CLK);
    #1;
    RST            = 1'b1;
    host_in_valid  = 1'b0;
    host_out_ready = 1'b0;
    idle(2);
  endtask

  task automatic test_cfg_packet();
    int w;
    int pd0 = pd_cnt;
    send_word(32'h0000_0003, 1'b0, w);
    cfg_q.push_back(26'h2AA_0001);
    send_word(32'h0AAA_0001, 1'b0, w);
    cfg_q.push_back(26'h000_0002);
    send_word(32'h0000_0002, 1'b0, w);
    cfg_q.push_back(26'h3FF_FFFF);
    send_word(32'h03FF_FFFF, 1'b1, w);
    n_checks++;
    if (busy !== 1'b0 || cfg_q.size() != 0) begin
      n_fail++;
      $display("FAIL cfg_end: busy=%b pending=%0d expected busy=0 pending=0", busy, cfg_q.size());
    end
    n_checks++;
    if (pd_cnt - pd0 != 1) begin
      n_fail++;
      $display("FAIL cfg_pkt_done_count: got %0d expected 1", pd_cnt - pd0);
    end
  endtask

  task automatic test_inp_stall();
    int w;
    int pd0 = pd_cnt;
    send_word(32'h4000_0004, 1'b0, w);
    inp_q.push_back(32'hA000_0001);
    send_word(32'hA000_0001, 1'b0, w);
    inp_q.push_back(32'hA000_0002);
    send_word(32'hA000_0002, 1'b0, w);
    inp_q.push_back(32'hA000_0003);
    host_in_data        = 32'hA000_0003;
    host_in_valid       = 1'b1;
    npu_input_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_checks++;
      if (host_in_ready !== 1'b0 || npu_input_fifo_write_enable !== 1'b0) begin
        n_fail++;
        $display("FAIL inp_stall: ready=%b we=%b expected 0 0", host_in_ready, npu_input_fifo_write_enable);
      end
      @(posedge CLK);
      #1;
    end
    npu_input_fifo_full = 1'b0;
    send_word(32'hA000_0003, 1'b0, w);
    inp_q.push_back(32'hA000_0004);
    send_word(32'hA000_0004, 1'b1, w);
    n_checks++;
    if (inp_q.size() != 0 || pd_cnt - pd0 != 1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL inp_end: pending=%0d pkt_done=%0d busy=%b expected 0 1 0",
               inp_q.size(), pd_cnt - pd0, busy);
    end
  endtask

  task automatic test_drop();
    int w;
    send_word(32'hC000_0002, 1'b0, w);
    n_checks++;
    if (bad_header !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_hdr: bad_header=%b busy=%b expected 1 1", bad_header, busy);
    end
    send_word(32'h1234_5678, 1'b0, w);
    send_word(32'h0BAD_0BAD, 1'b1, w);
    send_word(32'h0000_0001, 1'b0, w);
    cfg_q.push_back(26'h123_4567);
    send_word(32'h0123_4567, 1'b1, w);
    n_checks++;
    if (bad_header !== 1'b1 || cfg_q.size() != 0) begin
      n_fail++;
      $display("FAIL drop_end: bad_header=%b pending=%0d expected 1 0", bad_header, cfg_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int w;
    int pd0;
    send_word(32'h4000_0004, 1'b0, w);
    inp_q.push_back(32'hB000_0001);
    send_word(32'hB000_0001, 1'b0, w);
    host_in_data  = 32'hB000_0002;
    host_in_valid = 1'b1;
    RST           = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({host_in_ready, npu_input_fifo_write_enable, busy, pkt_done, bad_header} !== 5'b0 ||
        npu_input_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset: ready=%b we=%b busy=%b done=%b bad=%b data=%h expected all 0",
               host_in_ready, npu_input_fifo_write_enable, busy, pkt_done, bad_header, npu_input_data);
    end
    @(posedge CLK);
    #1;
    RST           = 1'b1;
    host_in_valid = 1'b0;
    idle(2);
    pd0 = pd_cnt;
    send_word(32'h0000_0000, 1'b1, w);
    n_checks++;
    if (pd_cnt - pd0 != 1 || busy !== 1'b0 || inp_q.size() != 0) begin
      n_fail++;
      $display("FAIL mid_reset_after: pkt_done=%0d busy=%b pending=%0d expected 1 0 0",
               pd_cnt - pd0, busy, inp_q.size());
    end
  endtask

  task automatic test_output();
    int pat [5] = '{1, 0, 0, 1, 1};
    int n = 0;
    host_out_ready = 1'b0;
    npu_q.push_back(32'h11); out_q.push_back(32'h11);
    npu_q.push_back(32'h22); out_q.push_back(32'h22);
    npu_q.push_back(32'h33); out_q.push_back(32'h33);
    npu_output_fifo_empty = 1'b0;
    while (!host_out_valid && n < 20) begin
      idle(1);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      host_out_ready = pat[i][0];
      idle(1);
    end
    host_out_ready = 1'b1;
    n = 0;
    while (out_q.size() != 0 && n < 30) begin
      idle(1);
      n++;
    end
    idle(2);
    n_checks++;
    if (out_q.size() != 0 || npu_q.size() != 0 || host_out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL out_drain: pending=%0d npu_left=%0d valid=%b expected 0 0 0",
               out_q.size(), npu_q.size(), host_out_valid);
    end
    host_out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w1;
    int w2;
    int pd0 = pd_cnt;
    send_word(32'h4000_0000, 1'b1, w1);
    send_word(32'h0000_0000, 1'b1, w2);
    n_checks++;
    if (w1 != 0 || w2 != 0) begin
      n_fail++;
      $display("FAIL b2b_ready: wait cycles %0d/%0d expected 0/0", w1, w2);
    end
    n_checks++;
    if (pd_cnt - pd0 != 2 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_done: pkt_done=%0d busy=%b expected 2 0", pd_cnt - pd0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_packet();
    test_inp_stall();
    test_drop();
    test_reset_mid();
    test_output();
    test_back_to_back();
    idle(3);
    n_checks++;
    if (cfg_q.size() != 0 || inp_q.size() != 0 || out_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_scoreboard: cfg=%0d inp=%0d out=%0d expected 0 0 0",
               cfg_q.size(), inp_q.size(), out_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
